// File: rtl/bullet_launcher_if.sv
// Bus between the bullet launcher and its surroundings: fire/steering inputs,
// the VGA pixel probe, and the published bullet coordinates and status.
interface bullet_launcher_if;
    logic       refresh_tick;
    logic       fire;
    logic [9:0] x_shooter;
    logic [9:0] y_shooter;
    logic [1:0] dir;
    logic       hit;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] x_bullet;
    logic [9:0] y_bullet;
    logic       bullet_on;
    logic       busy;
    logic       exploding;
    logic       fired;

    modport master (
        output refresh_tick, fire, x_shooter, y_shooter, dir, hit, x, y,
        input  x_bullet, y_bullet, bullet_on, busy, exploding, fired
    );

    modport slave (
        input  refresh_tick, fire, x_shooter, y_shooter, dir, hit, x, y,
        output x_bullet, y_bullet, bullet_on, busy, exploding, fired
    );
endinterface

// File: rtl/bullet_launcher.sv
// Launches, moves and retires one 4x4 projectile per shooter; publishes its
// coordinates for hit detection and a per-pixel bullet_on for the VGA mux.
module bullet_launcher #(
    parameter int SPEED          = 4,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479,
    parameter int EXPLODE_TICKS  = 4,
    parameter int COOLDOWN_TICKS = 8,
    parameter int PARK_X         = 700,
    parameter int PARK_Y         = 500
) (
    input  logic               clk_50MHz,
    input  logic               reset,
    bullet_launcher_if.slave   bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FLYING  = 2'd1;
    localparam logic [1:0] EXPLODE = 2'd2;

    localparam int TICK_W = $clog2(EXPLODE_TICKS + 1);
    localparam int COOL_W = $clog2(COOLDOWN_TICKS + 1);

    localparam logic signed [11:0] SPEED_S = 12'(SPEED);
    localparam logic signed [11:0] X_LIM   = 12'(X_MAX - 3);
    localparam logic signed [11:0] Y_LIM   = 12'(Y_MAX - 3);
    localparam logic [9:0]         PARK_XV = 10'(PARK_X);
    localparam logic [9:0]         PARK_YV = 10'(PARK_Y);

    logic [1:0]        state_reg, state_next;
    logic [9:0]        x_bullet_reg, x_bullet_next;
    logic [9:0]        y_bullet_reg, y_bullet_next;
    logic              fired_reg, fired_next;
    logic [1:0]        dir_reg, dir_next;
    logic [TICK_W-1:0] tick_reg, tick_next;
    logic [COOL_W-1:0] cool_reg, cool_next;

    // Candidate carries two spare bits so x+3 near the top of the 10-bit
    // range can never wrap back into the legal window.
    logic signed [11:0] cand_x, cand_y;
    logic               cand_legal;

    always_comb begin
        cand_x = signed'({2'b00, x_bullet_reg});
        cand_y = signed'({2'b00, y_bullet_reg});
        case (dir_reg)
            2'b00:   cand_y = cand_y - SPEED_S;
            2'b01:   cand_x = cand_x + SPEED_S;
            2'b10:   cand_y = cand_y + SPEED_S;
            default: cand_x = cand_x - SPEED_S;
        endcase
        cand_legal = !cand_x[11] && (cand_x <= X_LIM) &&
                     !cand_y[11] && (cand_y <= Y_LIM);
    end

    always_comb begin
        state_next    = state_reg;
        x_bullet_next = x_bullet_reg;
        y_bullet_next = y_bullet_reg;
        fired_next    = 1'b0;
        dir_next      = dir_reg;
        tick_next     = tick_reg;
        cool_next     = cool_reg;
        case (state_reg)
            IDLE: begin
                if (bus.refresh_tick) begin
                    if (cool_reg != '0) begin
                        cool_next = cool_reg - COOL_W'(1);
                    end else if (bus.fire) begin
                        dir_next      = bus.dir;
                        x_bullet_next = bus.x_shooter + 10'd14;
                        y_bullet_next = bus.y_shooter + 10'd14;
                        fired_next    = 1'b1;
                        state_next    = FLYING;
                    end
                end
            end
            FLYING: begin
                // A hit freezes the bullet even if a frame tick lands on the same clock.
                if (bus.hit) begin
                    state_next = EXPLODE;
                    tick_next  = '0;
                end else if (bus.refresh_tick) begin
                    if (cand_legal) begin
                        x_bullet_next = cand_x[9:0];
                        y_bullet_next = cand_y[9:0];
                    end else begin
                        state_next = EXPLODE;
                        tick_next  = '0;
                    end
                end
            end
            EXPLODE: begin
                if (bus.refresh_tick) begin
                    if (tick_reg == TICK_W'(EXPLODE_TICKS - 1)) begin
                        x_bullet_next = PARK_XV;
                        y_bullet_next = PARK_YV;
                        cool_next     = COOL_W'(COOLDOWN_TICKS);
                        tick_next     = '0;
                        state_next    = IDLE;
                    end else begin
                        tick_next = tick_reg + TICK_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            x_bullet_reg <= PARK_XV;
            y_bullet_reg <= PARK_YV;
            fired_reg    <= 1'b0;
            dir_reg      <= 2'b00;
            tick_reg     <= '0;
            cool_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            x_bullet_reg <= x_bullet_next;
            y_bullet_reg <= y_bullet_next;
            fired_reg    <= fired_next;
            dir_reg      <= dir_next;
            tick_reg     <= tick_next;
            cool_reg     <= cool_next;
        end
    end

    logic [10:0] px, py, bx, by;
    always_comb begin
        px = {1'b0, bus.x};
        py = {1'b0, bus.y};
        bx = {1'b0, x_bullet_reg};
        by = {1'b0, y_bullet_reg};
    end

    assign bus.bullet_on = (state_reg != IDLE) &&
                           (px >= bx) && (px <= bx + 11'd3) &&
                           (py >= by) && (py <= by + 11'd3);
    assign bus.x_bullet  = x_bullet_reg;
    assign bus.y_bullet  = y_bullet_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.exploding = (state_reg == EXPLODE);
    assign bus.fired     = fired_reg;

endmodule

// File: tb/tb_bullet_launcher.sv
// Self-checking bench for bullet_launcher: directed scenarios plus a randomized
// run against a frame-level behavioural model of the projectile.
module tb_bullet_launcher;

    logic clk_50MHz = 1'b0;
    logic reset     = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    bullet_launcher_if bus ();

    bullet_launcher dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .bus       (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    localparam int DX [4] = '{0, 4, 0, -4};
    localparam int DY [4] = '{-4, 0, 4, 0};

    task automatic clear_inputs();
        bus.refresh_tick = 1'b0;
        bus.fire         = 1'b0;
        bus.x_shooter    = '0;
        bus.y_shooter    = '0;
        bus.dir          = 2'b00;
        bus.hit          = 1'b0;
        bus.x            = '0;
        bus.y            = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk_50MHz);
        reset = 1'b0;
        clear_inputs();
        @(negedge clk_50MHz);
        reset = 1'b1;
        @(negedge clk_50MHz);
    endtask

    // One frame strobe lasting exactly one clock; returns on the next negedge.
    task automatic tick();
        bus.refresh_tick = 1'b1;
        @(negedge clk_50MHz);
        bus.refresh_tick = 1'b0;
    endtask

    task automatic launch(input int xs, input int ys, input int d);
        bus.x_shooter = 10'(xs);
        bus.y_shooter = 10'(ys);
        bus.dir       = 2'(d);
        bus.fire      = 1'b1;
        tick();
        bus.fire      = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        bus.x = 10'd700;
        bus.y = 10'd500;
        #1;
        vectors++;
        if (bus.x_bullet !== 10'd700 || bus.y_bullet !== 10'd500) begin
            miscompares++;
            $display("FAIL reset_pos: got (%0d,%0d) expected (700,500)", bus.x_bullet, bus.y_bullet);
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.exploding !== 1'b0 || bus.fired !== 1'b0 || bus.bullet_on !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: busy=%b exploding=%b fired=%b bullet_on=%b expected all 0",
                     bus.busy, bus.exploding, bus.fired, bus.bullet_on);
        end
    endtask

    task automatic test_flight_up();
        apply_reset();
        launch(320, 416, 0);
        vectors++;
        if (bus.x_bullet !== 10'd334 || bus.y_bullet !== 10'd430 || bus.fired !== 1'b1) begin
            miscompares++;
            $display("FAIL up_launch: got (%0d,%0d) fired=%b expected (334,430) fired=1",
                     bus.x_bullet, bus.y_bullet, bus.fired);
        end
        @(negedge clk_50MHz);
        vectors++;
        if (bus.fired !== 1'b0) begin
            miscompares++;
            $display("FAIL up_fired_pulse: fired=%b expected 0 one cycle later", bus.fired);
        end
        tick();
        vectors++;
        if (bus.y_bullet !== 10'd426) begin
            miscompares++;
            $display("FAIL up_first_move: y=%0d expected 426", bus.y_bullet);
        end
        repeat (106) tick();
        vectors++;
        if (bus.y_bullet !== 10'd2 || bus.busy !== 1'b1 || bus.exploding !== 1'b0) begin
            miscompares++;
            $display("FAIL up_top: y=%0d busy=%b exploding=%b expected y=2 busy=1 exploding=0",
                     bus.y_bullet, bus.busy, bus.exploding);
        end
        tick();
        vectors++;
        if (bus.y_bullet !== 10'd2 || bus.exploding !== 1'b1) begin
            miscompares++;
            $display("FAIL up_edge_explode: y=%0d exploding=%b expected y=2 exploding=1",
                     bus.y_bullet, bus.exploding);
        end
        repeat (3) tick();
        vectors++;
        if (bus.exploding !== 1'b1 || bus.y_bullet !== 10'd2) begin
            miscompares++;
            $display("FAIL up_explode_hold: exploding=%b y=%0d expected 1 and 2", bus.exploding, bus.y_bullet);
        end
        tick();
        vectors++;
        if (bus.x_bullet !== 10'd700 || bus.y_bullet !== 10'd500 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL up_park: got (%0d,%0d) busy=%b expected (700,500) busy=0",
                     bus.x_bullet, bus.y_bullet, bus.busy);
        end
    endtask

    task automatic test_right_edge();
        apply_reset();
        launch(600, 100, 1);
        vectors++;
        if (bus.x_bullet !== 10'd614 || bus.y_bullet !== 10'd114) begin
            miscompares++;
            $display("FAIL right_launch: got (%0d,%0d) expected (614,114)", bus.x_bullet, bus.y_bullet);
        end
        repeat (5) tick();
        vectors++;
        if (bus.x_bullet !== 10'd634 || bus.y_bullet !== 10'd114 || bus.exploding !== 1'b0) begin
            miscompares++;
            $display("FAIL right_last_move: got (%0d,%0d) exploding=%b expected (634,114) exploding=0",
                     bus.x_bullet, bus.y_bullet, bus.exploding);
        end
        tick();
        vectors++;
        if (bus.x_bullet !== 10'd634 || bus.exploding !== 1'b1) begin
            miscompares++;
            $display("FAIL right_edge_explode: x=%0d exploding=%b expected 634 and 1", bus.x_bullet, bus.exploding);
        end
    endtask

    task automatic test_hit();
        apply_reset();
        launch(320, 416, 0);
        repeat (3) tick();
        vectors++;
        if (bus.y_bullet !== 10'd418) begin
            miscompares++;
            $display("FAIL hit_pre: y=%0d expected 418", bus.y_bullet);
        end
        bus.hit = 1'b1;
        @(negedge clk_50MHz);
        bus.hit = 1'b0;
        vectors++;
        if (bus.exploding !== 1'b1 || bus.y_bullet !== 10'd418) begin
            miscompares++;
            $display("FAIL hit_explode: exploding=%b y=%0d expected 1 and 418", bus.exploding, bus.y_bullet);
        end
        bus.x = 10'd337;
        bus.y = 10'd421;
        #1;
        vectors++;
        if (bus.bullet_on !== 1'b1) begin
            miscompares++;
            $display("FAIL hit_on_corner: bullet_on=%b expected 1 at (337,421)", bus.bullet_on);
        end
        bus.x = 10'd338;
        #1;
        vectors++;
        if (bus.bullet_on !== 1'b0) begin
            miscompares++;
            $display("FAIL hit_off_right: bullet_on=%b expected 0 at (338,421)", bus.bullet_on);
        end
        bus.x = 10'd334;
        bus.y = 10'd417;
        #1;
        vectors++;
        if (bus.bullet_on !== 1'b0) begin
            miscompares++;
            $display("FAIL hit_off_above: bullet_on=%b expected 0 at (334,417)", bus.bullet_on);
        end
        @(negedge clk_50MHz);
        bus.hit = 1'b1;
        tick();
        bus.hit = 1'b0;
        vectors++;
        if (bus.exploding !== 1'b1 || bus.y_bullet !== 10'd418 || bus.x_bullet !== 10'd334) begin
            miscompares++;
            $display("FAIL hit_repeat: exploding=%b pos=(%0d,%0d) expected 1 (334,418)",
                     bus.exploding, bus.x_bullet, bus.y_bullet);
        end
    endtask

    task automatic test_back_to_back();
        int  n;
        int  m;
        bit  wandered;
        bit  early_fire;
        apply_reset();
        bus.x_shooter = 10'd320;
        bus.y_shooter = 10'd416;
        bus.dir       = 2'b00;
        bus.fire      = 1'b1;
        tick();
        vectors++;
        if (bus.fired !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first_fire: fired=%b expected 1", bus.fired);
        end
        n = 0;
        wandered = 1'b0;
        early_fire = 1'b0;
        while (bus.busy === 1'b1 && n < 300) begin
            bus.dir = 2'($urandom_range(0, 3));
            tick();
            n++;
            if (bus.busy === 1'b1 && bus.x_bullet !== 10'd334) wandered = 1'b1;
            if (bus.fired === 1'b1) early_fire = 1'b1;
        end
        vectors++;
        if (wandered || early_fire) begin
            miscompares++;
            $display("FAIL b2b_trajectory: wandered=%b refire_while_busy=%b expected 0 and 0", wandered, early_fire);
        end
        // 108 flight frames (the last one hits the top edge) plus 4 explode frames.
        vectors++;
        if (n !== 112) begin
            miscompares++;
            $display("FAIL b2b_flight_len: park after %0d ticks expected 112", n);
        end
        bus.dir = 2'b00;
        m = 0;
        while (bus.fired !== 1'b1 && m < 30) begin
            tick();
            m++;
        end
        // Eight frames of cooldown drain, the next tick launches.
        vectors++;
        if (m !== 9) begin
            miscompares++;
            $display("FAIL b2b_cooldown: relaunch %0d ticks after park expected 9", m);
        end
        vectors++;
        if (bus.x_bullet !== 10'd334 || bus.y_bullet !== 10'd430) begin
            miscompares++;
            $display("FAIL b2b_relaunch_pos: got (%0d,%0d) expected (334,430)", bus.x_bullet, bus.y_bullet);
        end
        bus.fire = 1'b0;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        launch(320, 416, 0);
        repeat (2) tick();
        bus.hit = 1'b1;
        tick();
        bus.hit = 1'b0;
        vectors++;
        if (bus.exploding !== 1'b1 || bus.y_bullet !== 10'd422) begin
            miscompares++;
            $display("FAIL sim_hit_tick: exploding=%b y=%0d expected 1 and 422", bus.exploding, bus.y_bullet);
        end
        apply_reset();
        launch(320, 0, 0);
        repeat (3) tick();
        bus.hit = 1'b1;
        tick();
        bus.hit = 1'b0;
        vectors++;
        if (bus.exploding !== 1'b1 || bus.y_bullet !== 10'd2) begin
            miscompares++;
            $display("FAIL sim_hit_edge: exploding=%b y=%0d expected 1 and 2", bus.exploding, bus.y_bullet);
        end
        repeat (3) tick();
        vectors++;
        if (bus.exploding !== 1'b1) begin
            miscompares++;
            $display("FAIL sim_single_entry_hold: exploding=%b expected 1 after 3 ticks", bus.exploding);
        end
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.x_bullet !== 10'd700 || bus.y_bullet !== 10'd500) begin
            miscompares++;
            $display("FAIL sim_single_entry_park: busy=%b pos=(%0d,%0d) expected 0 (700,500)",
                     bus.busy, bus.x_bullet, bus.y_bullet);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        launch(320, 416, 0);
        repeat (2) tick();
        bus.x = 10'd334;
        bus.y = 10'd422;
        #1;
        vectors++;
        if (bus.bullet_on !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_pre_on: bullet_on=%b expected 1", bus.bullet_on);
        end
        #4 reset = 1'b0;
        #1;
        vectors++;
        if (bus.x_bullet !== 10'd700 || bus.y_bullet !== 10'd500 || bus.busy !== 1'b0 || bus.bullet_on !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_immediate: pos=(%0d,%0d) busy=%b bullet_on=%b expected (700,500) 0 0",
                     bus.x_bullet, bus.y_bullet, bus.busy, bus.bullet_on);
        end
        #2 reset = 1'b1;
        @(negedge clk_50MHz);
        launch(100, 200, 1);
        vectors++;
        if (bus.fired !== 1'b1 || bus.x_bullet !== 10'd114 || bus.y_bullet !== 10'd214) begin
            miscompares++;
            $display("FAIL areset_relaunch: fired=%b pos=(%0d,%0d) expected 1 (114,214)",
                     bus.fired, bus.x_bullet, bus.y_bullet);
        end
    endtask

    // Frame-level model: a bullet is parked, flying or exploding; position and
    // counters are plain integers updated by the rules for each clock.
    task automatic test_random();
        int  m_mode, m_x, m_y, m_dir, m_frames, m_cool;
        int  nx, ny, px, py;
        bit  m_fired, m_on, tk, fr, ht;
        apply_reset();
        m_mode = 0; m_x = 700; m_y = 500; m_dir = 0; m_frames = 0; m_cool = 0;
        for (int i = 0; i < 4000; i++) begin
            tk = ($urandom_range(0, 1) == 1);
            fr = ($urandom_range(0, 3) != 0);
            ht = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1) begin
                px = m_x + int'($urandom_range(0, 5)) - 1;
                py = m_y + int'($urandom_range(0, 5)) - 1;
            end else begin
                px = int'($urandom_range(0, 1023));
                py = int'($urandom_range(0, 1023));
            end
            if (px < 0) px = 0;
            if (py < 0) py = 0;
            bus.refresh_tick = tk;
            bus.fire         = fr;
            bus.hit          = ht;
            bus.dir          = 2'($urandom_range(0, 3));
            bus.x_shooter    = 10'($urandom_range(0, 620));
            bus.y_shooter    = 10'($urandom_range(0, 460));
            bus.x            = 10'(px);
            bus.y            = 10'(py);
            px = int'(bus.x);
            py = int'(bus.y);
            m_fired = 1'b0;
            if (m_mode == 0) begin
                if (tk) begin
                    if (m_cool > 0) m_cool--;
                    else if (fr) begin
                        m_x = int'(bus.x_shooter) + 14;
                        m_y = int'(bus.y_shooter) + 14;
                        m_dir = int'(bus.dir);
                        m_fired = 1'b1;
                        m_mode = 1;
                    end
                end
            end else if (m_mode == 1) begin
                if (ht) begin
                    m_mode = 2;
                    m_frames = 0;
                end else if (tk) begin
                    nx = m_x + DX[m_dir];
                    ny = m_y + DY[m_dir];
                    if (nx >= 0 && nx + 3 <= 639 && ny >= 0 && ny + 3 <= 479) begin
                        m_x = nx;
                        m_y = ny;
                    end else begin
                        m_mode = 2;
                        m_frames = 0;
                    end
                end
            end else begin
                if (tk) begin
                    m_frames++;
                    if (m_frames == 4) begin
                        m_mode = 0;
                        m_x = 700;
                        m_y = 500;
                        m_cool = 8;
                    end
                end
            end
            m_on = (m_mode != 0) && px >= m_x && px <= m_x + 3 && py >= m_y && py <= m_y + 3;
            @(negedge clk_50MHz);
            vectors++;
            if (int'(bus.x_bullet) != m_x || int'(bus.y_bullet) != m_y ||
                bus.busy !== (m_mode != 0) || bus.exploding !== (m_mode == 2) ||
                bus.fired !== m_fired || bus.bullet_on !== m_on) begin
                miscompares++;
                $display("FAIL rand_cycle_%0d: got pos=(%0d,%0d) busy=%b expl=%b fired=%b on=%b expected pos=(%0d,%0d) busy=%b expl=%b fired=%b on=%b",
                         i, bus.x_bullet, bus.y_bullet, bus.busy, bus.exploding, bus.fired, bus.bullet_on,
                         m_x, m_y, (m_mode != 0), (m_mode == 2), m_fired, m_on);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk_50MHz);
        reset = 1'b1;
        @(negedge clk_50MHz);
        test_reset();
        test_flight_up();
        test_right_edge();
        test_hit();
        test_back_to_back();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
